// File: rtl/multi_clock_divider.sv
// NUM_CH independent 50%-duty clock dividers with shadowed divisor reload,
// per-channel enable, rising-edge tick pulses and a global phase-align sync.

module mcd_channel #(
  parameter int               DIV_W       = 8,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = 8'd15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             sync,
  input  logic [DIV_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] next_div;
  logic             apply;

  // A load arriving on the application cycle is the freshest value, so it wins.
  assign next_div = load ? div_in : shadow;
  assign apply    = pending | load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      active  <= DIV_DEFAULT;
      shadow  <= DIV_DEFAULT;
    end else begin
      tick <= 1'b0;
      if (sync) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        state   <= en ? RUN : IDLE;
        pending <= 1'b0;
        if (apply) begin
          active <= next_div;
          shadow <= next_div;
        end
      end else begin
        if (load) begin
          shadow  <= div_in;
          pending <= 1'b1;
        end
        case (state)
          IDLE: begin
            cnt     <= '0;
            clk_out <= 1'b0;
            if (en) state <= RUN;
          end
          RUN: begin
            if (cnt != active) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              if (clk_out) begin
                clk_out <= 1'b0;
              end else begin
                // Only the start of a high phase may swap the divisor.
                if (apply) begin
                  active  <= next_div;
                  shadow  <= next_div;
                  pending <= 1'b0;
                end
                if (en) begin
                  clk_out <= 1'b1;
                  tick    <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end
          end
        endcase
      end
    end
  end
endmodule

module multi_clock_divider #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       load,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);
  localparam logic [DIV_W-1:0] DEF = DIV_DEFAULT[DIV_W-1:0];

  logic [NUM_CH-1:0][DIV_W-1:0] div_lane;
  assign div_lane = div_in;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mcd_channel #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DEF)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[g]),
      .load    (load[g]),
      .sync    (sync),
      .div_in  (div_lane[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench: expected tick cycles are queued as stimulus is applied and
// popped by a monitor as the DUT pulses; point checks cover phase lengths.

module tb_multi_clock_divider;
  localparam int NUM_CH = 2;
  localparam int DIV_W  = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH*DIV_W-1:0] div_in;
  logic [NUM_CH-1:0]       load;
  logic                    sync;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pending;

  multi_clock_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_DEFAULT(15)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .div_in  (div_in),
    .load    (load),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  int lo = 1, hi = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  // Tick events encoded as cycle*16 + channel, kept sorted.
  task automatic push_exp(input int ch, input int c);
    int v;
    int i;
    v = c * 16 + ch;
    i = 0;
    while (i < exp_q.size() && exp_q[i] < v) i++;
    exp_q.insert(i, v);
  endtask

  task automatic push_periodic(input int ch, input int first, input int period, input int last);
    for (int c = first; c <= last; c += period) push_exp(ch, c);
  endtask

  always @(negedge clk) begin
    if (cyc >= lo && cyc <= hi) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (tick[ch]) begin
          if (exp_q.size() == 0) chk("tick_unexpected", cyc * 16 + ch, 0);
          else                   chk("tick", cyc * 16 + ch, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic end_window();
    wait_cyc(hi + 1);
    chk("tick_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b1;
    en     = '0;
    load   = '0;
    sync   = 1'b0;
    div_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, r, s, s0, s1, s2;
    reset  = 1'b1;
    en     = '0;
    load   = '0;
    sync   = 1'b0;
    div_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pending", pending, 0);

    // A: defaults, both channels clk/32
    apply_reset();
    p0 = cyc + 1;
    lo = cyc + 1; hi = p0 + 90;
    push_periodic(0, p0 + 16, 32, hi);
    push_periodic(1, p0 + 16, 32, hi);
    en = 2'b11;
    wait_cyc(p0 + 15); chk("A_low_before_rise", clk_out, 2'b00);
    wait_cyc(p0 + 16); chk("A_first_rise", clk_out, 2'b11);
    wait_cyc(p0 + 31); chk("A_high_end", clk_out, 2'b11);
    wait_cyc(p0 + 32); chk("A_fall", clk_out, 2'b00);
    chk("A_pending", pending, 2'b00);
    end_window();

    // B: ch0 load D=0 during high phase
    apply_reset();
    p0 = cyc + 1; r = p0 + 16;
    lo = cyc + 1; hi = r + 70;
    push_exp(0, r);
    push_periodic(0, r + 32, 2, hi);
    push_periodic(1, r, 32, hi);
    en = 2'b11;
    wait_cyc(r + 4); load = 2'b01; div_in = {8'hAA, 8'd0};
    wait_cyc(r + 5); load = 2'b00; chk("B_pending_set", pending, 2'b01);
    wait_cyc(r + 31); chk("B_pending_hold", pending, 2'b01);
    wait_cyc(r + 32); chk("B_pending_clear", pending, 2'b00);
    wait_cyc(r + 33); chk("B_div2_low", clk_out, 2'b10);
    wait_cyc(r + 34); chk("B_div2_high", clk_out, 2'b11);
    end_window();

    // C: two loads, last wins; ch1 disabled stays quiet
    apply_reset();
    p0 = cyc + 1; r = p0 + 16;
    lo = cyc + 1; hi = r + 70;
    push_exp(0, r); push_exp(0, r + 32); push_exp(0, r + 48); push_exp(0, r + 64);
    en = 2'b01;
    wait_cyc(r + 2); load = 2'b01; div_in = {8'd0, 8'd3};
    wait_cyc(r + 3); load = 2'b00;
    wait_cyc(r + 6); load = 2'b01; div_in = {8'd0, 8'd7};
    wait_cyc(r + 7); load = 2'b00;
    wait_cyc(r + 31); chk("C_pending", pending, 2'b01);
    wait_cyc(r + 39); chk("C_high8_end", clk_out, 2'b01);
    wait_cyc(r + 40); chk("C_fall", clk_out, 2'b00);
    end_window();

    // D: en dropped mid-high (D=4) finishes period then idles
    apply_reset();
    s = cyc + 1;
    lo = cyc + 1; hi = s + 40;
    push_exp(0, s + 5); push_exp(0, s + 26); push_exp(0, s + 36);
    en = 2'b01; load = 2'b01; sync = 1'b1; div_in = {8'd0, 8'd4};
    wait_cyc(s); load = 2'b00; sync = 1'b0; chk("D_sync_load_pending", pending, 2'b00);
    wait_cyc(s + 7); en = 2'b00;
    wait_cyc(s + 9); chk("D_high_full", clk_out, 2'b01);
    wait_cyc(s + 10); chk("D_fall", clk_out, 2'b00);
    wait_cyc(s + 15); chk("D_no_rise", clk_out, 2'b00);
    wait_cyc(s + 20); chk("D_idle", clk_out, 2'b00); en = 2'b01;
    wait_cyc(s + 26); chk("D_rerise", clk_out, 2'b01);
    end_window();

    // E: sync phase alignment
    apply_reset();
    s0 = cyc + 1; s1 = s0 + 21; s2 = s1 + 11;
    lo = cyc + 1; hi = s2 + 16;
    push_exp(0, s0 + 3); push_exp(0, s0 + 9); push_exp(0, s0 + 15);
    push_exp(1, s0 + 6); push_exp(1, s0 + 18);
    push_exp(0, s1 + 3); push_exp(0, s1 + 9); push_exp(1, s1 + 6);
    push_periodic(0, s2 + 3, 6, hi);
    push_periodic(1, s2 + 3, 6, hi);
    en = 2'b11; load = 2'b11; sync = 1'b1; div_in = {8'd5, 8'd2};
    wait_cyc(s0); load = 2'b00; sync = 1'b0;
    wait_cyc(s1 - 1); sync = 1'b1;
    wait_cyc(s1); sync = 1'b0; chk("E_sync_zero", clk_out, 2'b00); chk("E_sync_tick", tick, 2'b00);
    wait_cyc(s1 + 2); chk("E_pre_rise", clk_out, 2'b00);
    wait_cyc(s1 + 3); chk("E_ch0_rise", clk_out, 2'b01);
    wait_cyc(s2 - 1); sync = 1'b1; load = 2'b10; div_in = {8'd2, 8'd0};
    wait_cyc(s2); sync = 1'b0; load = 2'b00;
    chk("E_sync2_zero", clk_out, 2'b00); chk("E_sync2_pending", pending, 2'b00);
    wait_cyc(s2 + 3); chk("E_aligned_rise", clk_out, 2'b11);
    end_window();

    // F: async reset mid-high, divisor reverts to default
    apply_reset();
    p0 = cyc + 1; r = p0 + 16;
    lo = cyc + 1; hi = r + 2;
    push_exp(0, r); push_exp(1, r);
    en = 2'b11;
    wait_cyc(r + 1); load = 2'b01; div_in = {8'd0, 8'd2};
    wait_cyc(r + 2); load = 2'b00;
    end_window();
    chk("F_pre_high", clk_out, 2'b11);
    chk("F_pre_pending", pending, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk("F_async_clk_out", clk_out, 2'b00);
    chk("F_async_tick", tick, 2'b00);
    chk("F_async_pending", pending, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    p0 = cyc + 1;
    lo = cyc + 1; hi = p0 + 55;
    push_periodic(0, p0 + 16, 32, hi);
    push_periodic(1, p0 + 16, 32, hi);
    wait_cyc(p0 + 15); chk("F_default_low", clk_out, 2'b00);
    wait_cyc(p0 + 16); chk("F_default_rise", clk_out, 2'b11);
    end_window();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
Parametrised successor to the fixed /2 and /32 divider. It provides NUM_CH independent, run-time programmable clock-enable/divided-clock channels from one source clock. Each channel has 50% duty and a glitch-free divisor reload at period boundaries, plus per-channel enable, a global phase-align sync, and per-channel rising-edge tick pulses. It sits beside the existing divider and feeds the ADC/DAC sequencing and slow housekeeping logic.

Parameters:
NUM_CH, 2, number of independent divider channels (1..16)
DIV_W, 8, width of each channel's half-period divisor field
DIV_DEFAULT, 15, half-period divisor loaded at reset in every channel (15 gives clk/32)

Ports:
clk  input  1  source clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
en  input  NUM_CH  per-channel run enable
div_in  input  NUM_CH*DIV_W  packed divisor values; channel i uses bits [i*DIV_W +: DIV_W]
load  input  NUM_CH  per-channel 1-cycle strobe that captures div_in slice into the shadow register
sync  input  1  1-cycle strobe that restarts all channels phase-aligned
clk_out  output  NUM_CH  divided clocks, registered
tick  output  NUM_CH  1-cycle pulse coincident with each clk_out rising edge, registered
pending  output  NUM_CH  high while a loaded divisor awaits application

Behaviour:
- Reset (async, any time, including mid-period): cnt=0, clk_out=0, tick=0, pending=0, active=shadow=DIV_DEFAULT, all channels in IDLE.
- Per channel: active divisor D (DIV_W bits), counter cnt (DIV_W bits, range 0..D).
- Output period = 2*(D+1) clk cycles, high time = low time = D+1. D=0 gives clk/2; D=2^DIV_W-1 is the maximum.
- States: IDLE (clk_out=0, cnt=0) and RUN.
  - IDLE->RUN on the first cycle en=1. RUN counts from cnt=0 with clk_out=0.
  - First rising edge occurs D+1 cycles after the first RUN cycle.
- RUN, each cycle:
  - cnt!=D: cnt+1.
  - cnt==D: cnt<=0 and clk_out toggles, with the following boundary rules.
    - Falling toggle (clk_out=1->0): always taken. The divisor is never changed here.
    - Rising toggle point (clk_out=0): if pending, active<=shadow and pending<=0 first. The new D applies to the period starting now.
    - Rising toggle point with en=0: no rise. Go to IDLE (clk_out stays 0, cnt=0). A pending divisor is still applied.
    - Rising toggle point with en=1: clk_out<=1 and tick<=1 for exactly one cycle.
- en deasserted mid-period: the channel completes the current period, so no runt pulse. en reasserted before the boundary: the channel continues uninterrupted.
- load[i]=1: shadow<=div_in slice, pending<=1. A repeated load before application overwrites the shadow (last value wins). load has no effect on clk_out or cnt.
- Glitch-free rule: clk_out never produces a high or low phase shorter than min(D_old, D_new)+1 cycles.
- sync=1 (all channels, overrides counting):
  - cnt<=0, clk_out<=0, tick<=0.
  - Pending shadows are applied immediately. If load[i] is in the same cycle, the newly presented div_in slice is applied directly and pending[i]<=0.
  - Channels with en=1 are in RUN from the next cycle. All enabled channels with equal D rise on the same cycle.
- Channels are fully independent except for sync.
- tick never asserts in IDLE or during reset.

Test Plan:
- Reset, en=2'b11, defaults (D=15) -> clk_out[i] first rises 16 cycles after the first RUN cycle. Period 32, 16 high/16 low. tick pulses once per 32 cycles, aligned to the rise.
- Ch0 load D=0 mid-high-phase -> pending=1 until the next rising boundary. The current period completes at 32. Afterwards clk_out[0] is clk/2 (1 high/1 low) and pending=0. Ch1 is unaffected.
- Two loads (D=3 then D=7) before the boundary -> D=7 is applied: period 16. No phase shorter than 4 cycles at the transition.
- en[0] dropped 3 cycles into a high phase (D=4) -> high lasts 5, low lasts 5, then clk_out[0] stays 0 with no tick. Re-enable -> rise after 5 cycles.
- Channels with D=2 and D=5 running, sync pulse -> both outputs 0 the next cycle. Ch0 rises 3 cycles later, ch1 6 cycles later. Sync with load[1] (D=2) -> both channels rise together 3 cycles later.
- reset asserted mid-high phase -> clk_out, tick, and pending go 0 immediately (asynchronously). D reverts to 15 after release.
